// File: rtl/traffic_state_gen.sv
// Traffic-light phase generator: 1 s prescaler, GREEN/YELLOW/RED phase FSM with
// per-phase seconds countdown, pedestrian early-end of green and illegal-state recovery.
module traffic_state_gen #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned GREEN_T  = 10,
    parameter int unsigned YELLOW_T = 3,
    parameter int unsigned RED_T    = 8,
    parameter int unsigned PED_MIN  = 2,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ped_req,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] sec_left,
    output logic             tick
);

    localparam int unsigned PW = $clog2(TICK_DIV);

    localparam logic [PW-1:0]    PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] RED_LD    = CNT_W'(RED_T);
    localparam logic [CNT_W-1:0] PED_LD    = CNT_W'(PED_MIN);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [2:0] {
        GREEN  = 3'd0,
        YELLOW = 3'd1,
        RED    = 3'd2
    } phase_t;

    // state_q is a plain vector so codes 3..7 stay representable for recovery
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] sec_q, sec_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             tick_q, tick_d;
    logic             ped_pend_q, ped_pend_d;
    logic             ped_s1, ped_s2, ped_s3;
    logic             ped_edge;

    assign ped_edge = ped_s2 & ~ped_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_s1 <= 1'b0;
            ped_s2 <= 1'b0;
            ped_s3 <= 1'b0;
        end else begin
            ped_s1 <= ped_req;
            ped_s2 <= ped_s1;
            ped_s3 <= ped_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= GREEN;
            sec_q      <= GREEN_LD;
            pre_q      <= '0;
            tick_q     <= 1'b0;
            ped_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            pre_q      <= pre_d;
            tick_q     <= tick_d;
            ped_pend_q <= ped_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sec_d      = sec_q;
        pre_d      = pre_q;
        tick_d     = 1'b0;
        ped_pend_d = ped_pend_q;

        if (en) begin
            if (pre_q == PRE_LAST) begin
                pre_d  = '0;
                tick_d = 1'b1;
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end

        // A tick already emitted is consumed even if en has just dropped,
        // so a freeze never loses a second.
        case (state_q)
            GREEN: begin
                if (ped_edge) begin
                    ped_pend_d = 1'b1;
                end
                if (tick_q) begin
                    if (ped_pend_q && (sec_q > PED_LD)) begin
                        sec_d = PED_LD;
                    end else if (sec_q > ONE) begin
                        sec_d = sec_q - ONE;
                    end else begin
                        state_d    = YELLOW;
                        sec_d      = YELLOW_LD;
                        ped_pend_d = 1'b0;
                    end
                end
            end
            YELLOW: begin
                if (tick_q) begin
                    if (sec_q > ONE) begin
                        sec_d = sec_q - ONE;
                    end else begin
                        state_d = RED;
                        sec_d   = RED_LD;
                    end
                end
            end
            RED: begin
                if (tick_q) begin
                    if (sec_q > ONE) begin
                        sec_d = sec_q - ONE;
                    end else begin
                        state_d = GREEN;
                        sec_d   = GREEN_LD;
                    end
                end
            end
            default: begin
                state_d    = RED;
                sec_d      = RED_LD;
                pre_d      = '0;
                tick_d     = 1'b0;
                ped_pend_d = 1'b0;
            end
        endcase
    end

    assign state    = state_q;
    assign sec_left = sec_q;
    assign tick     = tick_q;

endmodule

// File: tb/tb_traffic_state_gen.sv
// Directed bench for traffic_state_gen: table-driven free-run sequence plus
// hand-written pedestrian, freeze, async-reset and illegal-state sequences.
module tb_traffic_state_gen;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       ped_req;
    logic [2:0] state;
    logic [3:0] sec_left;
    logic       tick;

    int total;
    int bad;
    int len;

    typedef struct {
        logic       en;
        logic       ped;
        logic [2:0] st;
        logic [3:0] sec;
        logic       tk;
    } vec_t;

    vec_t vecs[48];
    int   ph_st[6];
    int   ph_sec[6];

    traffic_state_gen #(
        .TICK_DIV (4),
        .GREEN_T  (3),
        .YELLOW_T (1),
        .RED_T    (2),
        .PED_MIN  (1),
        .CNT_W    (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .ped_req  (ped_req),
        .state    (state),
        .sec_left (sec_left),
        .tick     (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Advance until the phase changes; returns the edges taken.
    task automatic run_until_change(input string name, output int cnt);
        logic [2:0] s0;
        s0  = state;
        cnt = 0;
        while (state == s0 && cnt < 100) begin
            step();
            cnt++;
        end
        if (state == s0) begin
            total++;
            bad++;
            $display("FAIL %s timeout got_state=%0d", name, state);
        end
    endtask

    task automatic expect_phase(input string name, input int st, input int sec, input int n);
        int c;
        run_until_change(name, c);
        chk({name, "_len"}, c, n);
        chk({name, "_state"}, state, st);
        chk({name, "_sec"}, sec_left, sec);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        en      = 1'b0;
        ped_req = 1'b0;

        // After edge n (n>=1) the FSM has taken (n-1)/4 second steps; tick follows every 4th edge.
        ph_st  = '{0, 0, 0, 1, 2, 2};
        ph_sec = '{3, 2, 1, 1, 2, 1};
        for (int n = 1; n <= 48; n++) begin
            int u;
            u = ((n - 1) / 4) % 6;
            vecs[n-1].en  = 1'b1;
            vecs[n-1].ped = 1'b0;
            vecs[n-1].st  = 3'(ph_st[u]);
            vecs[n-1].sec = 4'(ph_sec[u]);
            vecs[n-1].tk  = ((n % 4) == 0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", state, 0);
        chk("reset_sec", sec_left, 3);
        chk("reset_tick", tick, 0);
        rst_n = 1'b1;

        // free-running sequence, two full periods
        for (int i = 0; i < 48; i++) begin
            en      = vecs[i].en;
            ped_req = vecs[i].ped;
            step();
            chk($sformatf("run%0d_state", i), state, vecs[i].st);
            chk($sformatf("run%0d_sec", i), sec_left, vecs[i].sec);
            chk($sformatf("run%0d_tick", i), tick, vecs[i].tk);
        end

        // pedestrian request at start of green
        step();
        chk("ped_start_state", state, 0);
        chk("ped_start_sec", sec_left, 3);
        ped_req = 1'b1;
        repeat (4) step();
        chk("ped_short_state", state, 0);
        chk("ped_short_sec", sec_left, 1);
        ped_req = 1'b0;
        expect_phase("ped_to_yellow", 1, 1, 4);
        expect_phase("yellow_to_red", 2, 2, 4);

        // button pressed in red and held: ignored, then one shortening per press
        ped_req = 1'b1;
        expect_phase("held_red", 0, 3, 8);
        expect_phase("held_green", 1, 1, 12);
        expect_phase("held_yellow", 2, 2, 4);
        ped_req = 1'b0;
        expect_phase("release_red", 0, 3, 8);
        ped_req = 1'b1;
        expect_phase("press_green", 1, 1, 8);
        expect_phase("press_yellow", 2, 2, 4);
        expect_phase("press_red", 0, 3, 8);
        expect_phase("press_green2", 1, 1, 12);
        ped_req = 1'b0;
        expect_phase("idle_yellow", 2, 2, 4);
        expect_phase("idle_red", 0, 3, 8);

        // freeze mid-green with sec_left=2
        repeat (5) step();
        chk("pre_freeze_state", state, 0);
        chk("pre_freeze_sec", sec_left, 2);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("freeze%0d_state", i), state, 0);
            chk($sformatf("freeze%0d_sec", i), sec_left, 2);
            chk($sformatf("freeze%0d_tick", i), tick, 0);
        end
        en = 1'b1;
        expect_phase("thaw_green", 1, 1, 7);

        // asynchronous reset mid-yellow while tick is high
        repeat (3) step();
        chk("pre_reset_state", state, 1);
        chk("pre_reset_tick", tick, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_state", state, 0);
        chk("async_reset_sec", sec_left, 3);
        chk("async_reset_tick", tick, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        // counted from the first edge after release
        expect_phase("post_reset_green", 1, 1, 13);
        expect_phase("post_reset_yellow", 2, 2, 4);
        expect_phase("post_reset_red", 0, 3, 8);

        // illegal state code held across one edge
        repeat (2) step();
        force dut.state_q = 3'd5;
        step();
        release dut.state_q;
        step();
        chk("failsafe_state", state, 2);
        chk("failsafe_sec", sec_left, 2);
        chk("failsafe_tick", tick, 0);
        // recovery may run once or twice depending on when the forced code clears
        run_until_change("failsafe_red", len);
        total++;
        if (len != 8 && len != 9) begin
            bad++;
            $display("FAIL failsafe_red_len got=%0d exp=8..9", len);
        end
        chk("failsafe_green_state", state, 0);
        chk("failsafe_green_sec", sec_left, 3);
        expect_phase("resume_green", 1, 1, 12);
        expect_phase("resume_yellow", 2, 2, 4);
        expect_phase("resume_red", 0, 3, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
